// File: rtl/apb_cmd_requester_if.sv
// Bundle of the command/response streams and the APB segment seen by apb_cmd_requester.
// master = requester side, slave = command source, response sink and APB completer.
interface apb_cmd_requester_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_W-1:0]     cmd_strb;
  logic [2:0]            cmd_prot;
  logic                  cmd_nse;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_tout;

  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0]            pprot;
  logic                  pnse;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_W-1:0]     pstrb;
  logic                  psel;
  logic                  penable;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot, cmd_nse,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_tout,
    input  rsp_ready,
    output paddr, pprot, pnse, pwrite, pwdata, pstrb, psel, penable,
    input  pready, pslverr, prdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot, cmd_nse,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_tout,
    output rsp_ready,
    input  paddr, pprot, pnse, pwrite, pwdata, pstrb, psel, penable,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_cmd_requester.sv
// APB4/APB5 requester: one command in flight, SETUP->ACCESS, single response register.
// Define APB_REQ_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES.
module apb_cmd_requester #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                 pclk,
  input logic                 presetn,
  apb_cmd_requester_if.master bus
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_W-1:0]     pstrb_q;
  logic [2:0]            pprot_q;
  logic                  pnse_q;
  logic                  pwrite_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_tout_q;
  logic                  cmd_ready;
  logic                  accept;
  logic                  tout_hit;

  assign cmd_ready = (state_q == StIdle) && (!rsp_valid_q || bus.rsp_ready);
  assign accept    = bus.cmd_valid && cmd_ready;

`ifdef APB_REQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tout_cnt_q;
  assign tout_hit = (tout_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tout_cfg;
  assign tout_hit        = 1'b0;
  assign unused_tout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= StIdle;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      pnse_q      <= 1'b0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tout_q  <= 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
      tout_cnt_q  <= '0;
`endif
    end else begin
      // A response only exists while idle, so draining it never races a completion.
      if (rsp_valid_q && bus.rsp_ready) rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            paddr_q   <= bus.cmd_addr;
            pwdata_q  <= bus.cmd_wdata;
            pstrb_q   <= bus.cmd_write ? bus.cmd_strb : '0;
            pprot_q   <= bus.cmd_prot;
            pnse_q    <= bus.cmd_nse;
            pwrite_q  <= bus.cmd_write;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          state_q   <= StAccess;
`ifdef APB_REQ_TIMEOUT_EN
          tout_cnt_q <= '0;
`endif
        end
        StAccess: begin
          if (bus.pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.pslverr;
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
            rsp_tout_q  <= 1'b0;
            state_q     <= StIdle;
          end else if (tout_hit) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_tout_q  <= 1'b1;
            state_q     <= StIdle;
          end else begin
`ifdef APB_REQ_TIMEOUT_EN
            tout_cnt_q <= tout_cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.pprot     = pprot_q;
  assign bus.pnse      = pnse_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_tout  = rsp_tout_q;

endmodule

// File: tb/tb_apb_cmd_requester.sv
// Directed bench for apb_cmd_requester: writes, reads with wait states, errors,
// response back-pressure, mid-transfer reset and ACCESS timeout behaviour.
module tb_apb_cmd_requester;
  logic pclk;
  logic presetn;
  int   n_checks;
  int   n_errors;

  apb_cmd_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_cmd_requester #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Offer one command, take the accept edge, then verify the SETUP phase.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input logic nse);
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.cmd_prot  = prot;
    bus.cmd_nse   = nse;
    bus.cmd_valid = 1'b1;
    #1;
    check("cmd_ready_idle", bus.cmd_ready, 1'b1);
    step();
    bus.cmd_valid = 1'b0;
    check("setup_psel", bus.psel, 1'b1);
    check("setup_penable", bus.penable, 1'b0);
    check("setup_paddr", bus.paddr, addr);
    check("setup_pwrite", bus.pwrite, wr);
    check("setup_pstrb", bus.pstrb, wr ? strb : 4'h0);
    check("setup_pprot", bus.pprot, prot);
    check("setup_pnse", bus.pnse, nse);
    if (wr) check("setup_pwdata", bus.pwdata, wdata);
    check("setup_rsp_valid", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    presetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.cmd_nse   = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    step();
    step();
    check("rst_psel", bus.psel, 1'b0);
    check("rst_penable", bus.penable, 1'b0);
    check("rst_paddr", bus.paddr, 32'h0);
    check("rst_pwdata", bus.pwdata, 32'h0);
    check("rst_pstrb", bus.pstrb, 4'h0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_tout", bus.rsp_tout, 1'b0);
    presetn = 1'b1;
    step();

    // 1: zero-wait write; pready high in SETUP must be ignored
    bus.pready = 1'b1;
    issue(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 3'b000, 1'b0);
    step();
    check("t1_access_psel", bus.psel, 1'b1);
    check("t1_access_penable", bus.penable, 1'b1);
    check("t1_access_rsp_valid", bus.rsp_valid, 1'b0);
    step();
    check("t1_done_psel", bus.psel, 1'b0);
    check("t1_done_penable", bus.penable, 1'b0);
    check("t1_rsp_valid", bus.rsp_valid, 1'b1);
    check("t1_rsp_err", bus.rsp_err, 1'b0);
    check("t1_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("t1_rsp_tout", bus.rsp_tout, 1'b0);
    step();
    check("t1_rsp_drained", bus.rsp_valid, 1'b0);
    check("t1_idle_paddr", bus.paddr, 32'h0000_0010);
    check("t1_idle_pwdata", bus.pwdata, 32'hA5A5_5A5A);

    // 2: read with 3 wait states, latency 5
    bus.pready = 1'b0;
    bus.prdata = 32'hDEAD_BEEF;
    issue(1'b0, 32'h0000_0020, 32'h1111_2222, 4'hF, 3'b001, 1'b0);
    step();
    check("t2_access_penable", bus.penable, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_wait_psel", bus.psel, 1'b1);
      check("t2_wait_penable", bus.penable, 1'b1);
      check("t2_wait_paddr", bus.paddr, 32'h0000_0020);
      check("t2_wait_pstrb", bus.pstrb, 4'h0);
      check("t2_wait_rsp_valid", bus.rsp_valid, 1'b0);
    end
    bus.pready = 1'b1;
    step();
    check("t2_rsp_valid", bus.rsp_valid, 1'b1);
    check("t2_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("t2_rsp_err", bus.rsp_err, 1'b0);
    check("t2_psel", bus.psel, 1'b0);
    step();

    // 3: write error with protection attributes
    bus.pslverr = 1'b1;
    issue(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'h3, 3'b010, 1'b1);
    step();
    check("t3_pprot", bus.pprot, 3'b010);
    check("t3_pnse", bus.pnse, 1'b1);
    step();
    check("t3_rsp_valid", bus.rsp_valid, 1'b1);
    check("t3_rsp_err", bus.rsp_err, 1'b1);
    check("t3_rsp_rdata", bus.rsp_rdata, 32'h0);
    bus.pslverr = 1'b0;
    step();

    // 4: response back-pressure blocks the next command
    bus.rsp_ready = 1'b0;
    bus.prdata    = 32'h1234_5678;
    issue(1'b0, 32'h0000_0034, 32'h0, 4'h0, 3'b000, 1'b0);
    step();
    step();
    check("t4_rsp_valid", bus.rsp_valid, 1'b1);
    bus.prdata    = 32'hFFFF_0000;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_0040;
    bus.cmd_wdata = 32'hCAFE_0040;
    bus.cmd_strb  = 4'hF;
    bus.cmd_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t4_cmd_ready_blocked", bus.cmd_ready, 1'b0);
      check("t4_rsp_held", bus.rsp_valid, 1'b1);
      check("t4_rdata_stable", bus.rsp_rdata, 32'h1234_5678);
      check("t4_paddr_held", bus.paddr, 32'h0000_0034);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("t4_cmd_ready_drain", bus.cmd_ready, 1'b1);
    step();
    bus.cmd_valid = 1'b0;
    check("t4_accept_psel", bus.psel, 1'b1);
    check("t4_accept_paddr", bus.paddr, 32'h0000_0040);
    check("t4_rsp_dropped", bus.rsp_valid, 1'b0);
    step();
    step();
    check("t4_second_rsp", bus.rsp_valid, 1'b1);
    step();

    // 5: reset during ACCESS
    bus.pready = 1'b0;
    issue(1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'b000, 1'b0);
    step();
    step();
    check("t5_in_access", bus.penable, 1'b1);
    presetn = 1'b0;
    step();
    check("t5_rst_psel", bus.psel, 1'b0);
    check("t5_rst_penable", bus.penable, 1'b0);
    check("t5_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("t5_rst_paddr", bus.paddr, 32'h0);
    presetn    = 1'b1;
    bus.pready = 1'b1;
    step();
    issue(1'b1, 32'h0000_0060, 32'h6060_6060, 4'hC, 3'b100, 1'b0);
    step();
    step();
    check("t5_post_rsp_valid", bus.rsp_valid, 1'b1);
    check("t5_post_rsp_err", bus.rsp_err, 1'b0);
    step();

    // 6: stalled completer
    bus.pready = 1'b0;
    bus.prdata = 32'h7777_8888;
`ifdef APB_REQ_TIMEOUT_EN
    issue(1'b0, 32'h0000_0070, 32'h0, 4'h0, 3'b000, 1'b0);
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      check("t6_wait_penable", bus.penable, 1'b1);
      check("t6_wait_rsp_valid", bus.rsp_valid, 1'b0);
    end
    step();
    check("t6_abort_psel", bus.psel, 1'b0);
    check("t6_abort_rsp_valid", bus.rsp_valid, 1'b1);
    check("t6_abort_err", bus.rsp_err, 1'b1);
    check("t6_abort_tout", bus.rsp_tout, 1'b1);
    check("t6_abort_rdata", bus.rsp_rdata, 32'h0);
    step();
    issue(1'b0, 32'h0000_0074, 32'h0, 4'h0, 3'b000, 1'b0);
    step();
    for (int i = 0; i < 7; i++) step();
    bus.pready = 1'b1;
    step();
    check("t6_late_rsp_valid", bus.rsp_valid, 1'b1);
    check("t6_late_err", bus.rsp_err, 1'b0);
    check("t6_late_tout", bus.rsp_tout, 1'b0);
    check("t6_late_rdata", bus.rsp_rdata, 32'h7777_8888);
`else
    issue(1'b0, 32'h0000_0070, 32'h0, 4'h0, 3'b000, 1'b0);
    step();
    for (int i = 0; i < 12; i++) begin
      step();
      check("t6_nowait_penable", bus.penable, 1'b1);
      check("t6_nowait_rsp_valid", bus.rsp_valid, 1'b0);
    end
    bus.pready = 1'b1;
    step();
    check("t6_late_rsp_valid", bus.rsp_valid, 1'b1);
    check("t6_late_tout", bus.rsp_tout, 1'b0);
    check("t6_late_rdata", bus.rsp_rdata, 32'h7777_8888);
`endif
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
